// File: rtl/dct_transpose_ctrl_pkg.sv
// Purpose: shared constants, FSM state type and transpose address helper for the DCT transpose controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dct_pkg;

    localparam int DATA_W = 24;               // coefficient width, equals RAM data width
    localparam int N      = 8;                // transform size
    localparam int LOG2N  = $clog2(N);
    localparam int ADDR_W = 2 * LOG2N;        // one N*N block of words
    localparam int BLK    = N * N;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        FLUSH
    } state_t;

    // Column-major read index -> row-major RAM address: low bits of the index
    // are the row, high bits the column, so swapping the halves gives row*N+col.
    function automatic logic [ADDR_W-1:0] tr_addr(input logic [ADDR_W-1:0] idx);
        return {idx[LOG2N-1:0], idx[ADDR_W-1:LOG2N]};
    endfunction

endpackage

// File: rtl/dct_tr_rd_pipe.sv
// Purpose: read-issue for the drain phase; holds the RAM address and the registered out_valid.
// Latency: word presented 1 cycle after issue (registered RAM read).
// Backpressure: on a stall the issued address is re-driven so the RAM re-reads the same word.
// Ports: clk/rst; i_en enables issue; i_idx is the column-major index to issue;
//        i_out_rdy is the downstream ready; o_issue pulses on each issue; o_addr is the
//        RAM read address; o_vld/o_idx describe the word currently presented.
module dct_tr_rd_pipe
    import dct_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic              i_out_rdy,
    output logic              o_issue,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_idx
);

    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_idx;
    logic              w_issue;

    // A new read may go out when the output slot is empty or is being emptied now.
    assign w_issue = i_en && (!r_vld || i_out_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_idx  <= '0;
        end else if (w_issue) begin
            r_vld  <= 1'b1;
            r_addr <= tr_addr(i_idx);
            r_idx  <= i_idx;
        end else if (i_out_rdy) begin
            r_vld  <= 1'b0;
        end
    end

    // Without a new issue the last address stays on the bus, keeping ram_dout stable.
    assign o_addr  = w_issue ? tr_addr(i_idx) : r_addr;
    assign o_issue = w_issue;
    assign o_vld   = r_vld;
    assign o_idx   = r_idx;

endmodule

// File: rtl/dct_transpose_ctrl.sv
// Purpose: fills the transpose RAM row-major from the row DCT and drains it column-major to the column DCT.
// Latency: first out_valid 2 cycles after the 64th write; full-rate drain is 64 cycles.
// Backpressure: in_ready low during DRAIN/FLUSH; out_ready low holds address and output word.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data row-major input;
//        ram_addr/ram_din/ram_we/ram_dout external single-port RAM; out_valid/out_ready/
//        out_data/out_col_last/out_blk_last column-major output; busy.
// Optional: DCT_TCTRL_DROP_CNT_EN adds drop_cnt[15:0], a saturating count of cycles with
//           in_valid high while in_ready is low.
module dct_transpose_ctrl
    import dct_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_col_last,
    output logic              out_blk_last,
    output logic              busy
`ifdef DCT_TCTRL_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] w_wr_cnt_nxt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] w_rd_cnt_nxt;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_issue;
    logic              w_out_vld;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_pres_idx;
    logic              w_rd_phase;

    assign w_rd_en    = (r_state == DRAIN);
    assign w_rd_phase = (r_state == DRAIN) || (r_state == FLUSH);

    dct_tr_rd_pipe u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_rd_en),
        .i_idx     (r_rd_cnt),
        .i_out_rdy (out_ready),
        .o_issue   (w_issue),
        .o_addr    (w_rd_addr),
        .o_vld     (w_out_vld),
        .o_idx     (w_pres_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, FILL: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    // Counter wraps to 0 naturally after the last word of the block.
                    w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    w_state_nxt  = (r_wr_cnt == ADDR_W'(BLK - 1)) ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if (w_issue) begin
                    w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                    if (r_rd_cnt == ADDR_W'(BLK - 1)) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (w_out_vld && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write strobe is combinational on the accept so a word lands in the same cycle.
    assign ram_we       = w_accept;
    assign ram_din      = in_data;
    assign ram_addr     = w_rd_phase ? w_rd_addr : r_wr_cnt;
    assign busy         = (r_state != IDLE);

    assign out_valid    = w_out_vld;
    assign out_data     = ram_dout;
    assign out_col_last = w_out_vld && (w_pres_idx[LOG2N-1:0] == LOG2N'(N - 1));
    assign out_blk_last = w_out_vld && (w_pres_idx == ADDR_W'(BLK - 1));

`ifdef DCT_TCTRL_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (in_valid && !in_ready && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Purpose: directed self-checking bench for dct_transpose_ctrl with a behavioural 64x24 RAM.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dct_transpose_ctrl;
    import dct_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_col_last;
    logic              out_blk_last;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dct_transpose_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_dout     (ram_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_col_last (out_col_last),
        .out_blk_last (out_blk_last),
        .busy         (busy)
    );

    // Single-port RAM with a registered read; read data is undefined during a write.
    logic [DATA_W-1:0] mem [0:BLK-1];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= 'x;
        end else begin
            ram_dout      <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready), 1);
        check("rst_ram_we",    32'(ram_we), 0);
        check("rst_ram_addr",  32'(ram_addr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy",      32'(busy), 0);
    endtask

    task automatic fill(input int base, input bit gap, input int n);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                check("gap_we", 32'(ram_we), 0);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DATA_W'(base + i);
            #1;
            check("fill_rdy",  32'(in_ready), 1);
            check("fill_we",   32'(ram_we), 1);
            check("fill_addr", 32'(ram_addr), i);
            check("fill_din",  32'(ram_din), base + i);
            if (i > 0) check("fill_busy", 32'(busy), 1);
        end
    endtask

    // Drains one block, checking column-major order, flags, stall stability and latency.
    task automatic drain(input int base, input bit toggle, input bit hold);
        int                k       = 0;
        int                cyc     = 0;
        int                first_v = -1;
        int                expv;
        logic              stalled = 1'b0;
        logic [DATA_W-1:0] sd      = '0;
        while (k < BLK && cyc < 600) begin
            @(negedge clk);
            out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            in_valid  = hold;
            in_data   = 24'hBADBAD;
            #1;
            check("drn_in_ready", 32'(in_ready), 0);
            check("drn_ram_we",   32'(ram_we), 0);
            if (cyc == 0) check("drn_busy", 32'(busy), 1);
            if (out_valid && first_v < 0) first_v = cyc;
            if (stalled) begin
                check("stall_vld", 32'(out_valid), 1);
                check("stall_dat", 32'(out_data), 32'(sd));
            end
            stalled = out_valid && !out_ready;
            sd      = out_data;
            if (out_valid && out_ready) begin
                expv = base + (k % N) * N + k / N;
                check("out_data",     32'(out_data), expv);
                check("out_col_last", 32'(out_col_last), ((k % N) == N - 1) ? 1 : 0);
                check("out_blk_last", 32'(out_blk_last), (k == BLK - 1) ? 1 : 0);
                k++;
            end else if (!out_valid) begin
                check("novld_flags", 32'({out_col_last, out_blk_last}), 0);
            end
            cyc++;
        end
        check("drn_count",   k, BLK);
        check("drn_latency", first_v, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("post_in_ready",  32'(in_ready), 1);
        check("post_busy",      32'(busy), 0);
        check("post_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        // Reset state.
        do_reset();

        // Full-rate block, ascending data, with upstream holding in_valid during drain.
        fill(0, 1'b0, BLK);
        drain(0, 1'b0, 1'b1);

        // Gapped fill, then drain under a 1,0,0,1 ready pattern.
        fill(1000, 1'b1, BLK);
        drain(1000, 1'b1, 1'b0);

        // Abort a partial block with reset, then a fresh block must come out alone.
        fill(5000, 1'b0, 30);
        do_reset();
        fill(7000, 1'b0, BLK);
        drain(7000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
